// File: rtl/pipeline_fetch_queue.sv
// rtl/pipeline_fetch_queue.sv - instruction prefetch queue with bypass, replay and flush
module pipeline_fetch_queue #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [WIDTH-1:0]           i_bus_in,
    input  logic                       i_bus_request,
    input  logic                       i_flag_pcraflip,
    input  logic                       i_flush,
    input  logic                       i_replay,
    input  logic                       i_instr_ready,
    output logic [WIDTH-1:0]           o_instr_out,
    output logic                       o_instr_valid,
    output logic                       o_fetch_req,
    output logic                       o_inc_pcra0,
    output logic                       o_inc_pcra1,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;

    logic             w_empty;
    logic             w_not_full;
    logic             w_fetch;
    logic [WIDTH-1:0] w_out;
    logic             w_valid;
    logic             w_pop;
    logic             w_pop_q;
    logic             w_push;

    // Circular pointers wrap at DEPTH-1 so non power-of-two depths work.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_not_full = (r_count < FULL_COUNT);

    // A full queue never fetches, even when a pop frees a slot this cycle;
    // refill starts on the following cycle.
    assign w_fetch = !i_rst && !i_bus_request && !i_flush && w_not_full;

    // Output select: replay beats queue head beats bypass; flush blanks the output.
    always_comb begin
        w_out   = '0;
        w_valid = 1'b0;
        if (!i_rst) begin
            if (i_replay) begin
                w_out   = r_last;
                w_valid = 1'b1;
            end else if (i_flush) begin
                w_out   = '0;
                w_valid = 1'b0;
            end else if (!w_empty) begin
                w_out   = r_mem[r_head];
                w_valid = 1'b1;
            end else if ((BYPASS != 0) && w_fetch) begin
                w_out   = i_bus_in;
                w_valid = 1'b1;
            end
        end
    end

    // A bypassed byte that is consumed in the same cycle is never stored.
    assign w_pop   = w_valid && i_instr_ready && !i_replay && !i_flush;
    assign w_pop_q = w_pop && !w_empty;
    assign w_push  = w_fetch && !(w_pop && w_empty);

    // Queue storage; contents are meaningless outside head..tail so no reset.
    always_ff @(negedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_bus_in;
        end
    end

    // Pointer, occupancy and last-consumed byte bookkeeping.
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_last <= w_out;
            end
            if (w_pop_q) begin
                r_head <= f_next(r_head);
            end
            if (w_push) begin
                r_tail <= f_next(r_tail);
            end
            case ({w_push, w_pop_q})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_instr_out   = w_out;
    assign o_instr_valid = w_valid;
    assign o_fetch_req   = w_fetch;
    assign o_inc_pcra0   = w_fetch && i_flag_pcraflip;
    assign o_inc_pcra1   = w_fetch && !i_flag_pcraflip;
    assign o_count       = r_count;

endmodule

// File: doc/pipeline_fetch_queue.md
PIPELINE_FETCH_QUEUE -- requirements
Module: pipeline_fetch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the instruction byte width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the prefetch queue depth; legal values are 2 to 16.
REQ-003 The block SHALL have parameter BYPASS, default 1; when 1, an empty queue forwards bus_in combinationally.
REQ-004 clk  input  1  single clock; all state updates on the falling edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 bus_in  input  WIDTH  byte presented on the data bus.
REQ-007 bus_request  input  1  bus stolen by another master; no fetch this cycle.
REQ-008 flag_pcraflip  input  1  selects which PC/RA counter advances on a fetch.
REQ-009 flush  input  1  control transfer; discard all queued bytes.
REQ-010 replay  input  1  re-present the last consumed byte instead of the queue head.
REQ-011 instr_ready  input  1  consumer accepts instr_out this cycle.
REQ-012 instr_out  output  WIDTH  instruction byte to the decoder.
REQ-013 instr_valid  output  1  instr_out is meaningful.
REQ-014 fetch_req  output  1  a fetch occurs this cycle; bus_in is sampled at the next falling edge.
REQ-015 inc_pcra0, inc_pcra1  output  1 each  counter increment strobes.
REQ-016 count  output  $clog2(DEPTH+1)  number of queued bytes.

Function
REQ-017 fetch_req SHALL be combinational: !rst & !bus_request & !flush & (count < DEPTH).
REQ-018 inc_pcra0 SHALL equal fetch_req & flag_pcraflip, and inc_pcra1 SHALL equal fetch_req & !flag_pcraflip; exactly one fires per fetch.
REQ-019 The queue SHALL be a circular buffer with head and tail pointers wrapping from DEPTH-1 to 0, with a separate occupancy count.
REQ-020 Output select, in priority order:
- replay=1: instr_out = last_instr, instr_valid = 1.
- count>0: instr_out = head entry, instr_valid = 1.
- count=0, BYPASS=1, fetch_req=1: instr_out = bus_in, instr_valid = 1.
- otherwise: instr_out = 0, instr_valid = 0.
REQ-021 A pop SHALL occur at the falling edge when instr_valid & instr_ready & !replay & !flush.
- A pop loads last_instr with instr_out.
- A pop from the queue advances head.
REQ-022 A push SHALL occur at the falling edge when fetch_req=1, except in the bypass case: count=0 and a pop of the bypassed byte occur together, and the byte is then not stored.
REQ-023 Simultaneous push and pop with count>0 SHALL leave count unchanged, advancing both pointers.
REQ-024 When full (count=DEPTH), fetch_req SHALL be 0 even if a pop occurs that cycle; the refill starts the following cycle.
REQ-025 replay=1 SHALL NOT pop; the queue SHALL still fill under REQ-017, and last_instr SHALL be held.
REQ-026 flush=1 SHALL clear count, head and tail at the falling edge and force instr_valid=0 that cycle unless replay=1; last_instr is kept.
REQ-027 A byte present on bus_in during a flush cycle SHALL be discarded, and no inc strobe fires.
REQ-028 bus_request=1 SHALL suppress push and inc strobes only; queued bytes SHALL continue to drain to the consumer.
REQ-029 Latency: a byte fetched into an empty queue SHALL appear on instr_out in the same cycle (BYPASS=1) or after one falling edge (BYPASS=0).

Reset
REQ-030 While rst=1:
- count, head, tail and last_instr SHALL be 0.
- fetch_req, inc_pcra0, inc_pcra1 and instr_valid SHALL be 0.
- instr_out SHALL be 0 unless replay=1, in which case it is 0 from last_instr.
REQ-031 Reset asserted mid-operation SHALL drop all queued bytes immediately, without waiting for a clock edge.
REQ-032 After rst deasserts, the first falling edge SHALL perform normal operation.

Verification (WIDTH=8, DEPTH=4)
REQ-033 Fill:
- Stimulus: instr_ready=0, bus_in=11,22,33,44,55 on successive cycles.
- Response: count goes 1..4; fetch_req=0 at count=4; 55 is not stored; 4 inc strobes.
- Then instr_ready=1: bytes 11,22,33,44 come out in order.
REQ-034 Bypass:
- Stimulus: empty queue, instr_ready=1, bus_in=A5.
- Response: instr_out=A5 and instr_valid=1 in the same cycle; count stays 0; last_instr=A5 after the edge.
REQ-035 Bus steal:
- Stimulus: count=2, bus_request=1 for 3 cycles, instr_ready=1.
- Response: both bytes drain; fetch_req, inc_pcra0 and inc_pcra1 stay 0; count=0; instr_valid then drops.
REQ-036 Flush:
- Stimulus: count=3, flush=1, bus_in=77.
- Response: count=0 after the edge; 77 is not stored; no inc strobe; instr_valid=0 during the flush cycle.
REQ-037 Replay:
- Stimulus: last popped byte=3C, replay=1 for 2 cycles, queue filling.
- Response: instr_out=3C for both cycles; no pop; count increments each cycle.
REQ-038 Async reset:
- Stimulus: count=3, rst pulsed between clock edges.
- Response: count=0, instr_valid=0 and fetch_req=0 immediately; normal fetching resumes at the first falling edge after release.
